// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Unsigned or two's-complement operation, chosen per operation via signed_mode.
// Optional build macro MULT_EARLY_EXIT_EN: RUN ends as soon as the remaining
// multiplier bits are all zero. The product is identical; only latency changes.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; operands are latched on the accepting edge
// S_RUN  | one shift-add iteration per clock
// S_DONE | single-cycle done pulse; p is valid
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   mcand;
  // acc = {partial sum (WIDTH+1), multiplier bits not yet consumed / low product bits}
  logic [2*WIDTH:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_step;
  logic [CNT_W-1:0]   cnt_step;
  logic [2*WIDTH-1:0] prod_step;
  logic               finish;
`ifdef MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0]   rem_mask;
`endif

  // Operand magnitudes and one shift-add iteration of the datapath
  always_comb begin
    a_mag     = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_mode && b[WIDTH-1]) ? -b : b;
    sum       = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    acc_step  = {sum, acc[WIDTH-1:0]} >> 1;
    cnt_step  = cnt - CNT_W'(1);
`ifdef MULT_EARLY_EXIT_EN
    // Low cnt_step bits of acc_step are the multiplier bits still to be
    // consumed; when they are all zero the rest is just a right shift.
    rem_mask  = ~({WIDTH{1'b1}} << cnt_step);
    finish    = (cnt_step == '0) || ((acc_step[WIDTH-1:0] & rem_mask) == '0);
    prod_step = acc_step[2*WIDTH-1:0] >> cnt_step;
`else
    finish    = (cnt_step == '0);
    prod_step = acc_step[2*WIDTH-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (finish) next_state = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture, iteration registers and the product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      p      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            acc    <= {{(WIDTH+1){1'b0}}, b_mag};
            cnt    <= CNT_W'(WIDTH);
            sign_q <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt_step;
          // Negating zero yields zero, so a zero product never turns nonzero
          if (finish) p <= sign_q ? -prod_step : prod_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed and randomised checks of seq_mult_param at
// WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_seq_mult_param;

  logic        clk;
  logic        rst_n;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_checks = 0;
  int n_errors = 0;
  int dn8 = 0, dn16 = 0;
  int exp_dn8 = 0, exp_dn16 = 0;

  seq_mult_param #(.WIDTH(8)) u_mult8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  seq_mult_param #(.WIDTH(16)) u_mult16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // count done pulses seen on each instance
  always @(posedge clk) begin
    if (done8)  dn8++;
    if (done16) dn16++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input int w, input logic sm,
                                           input logic [31:0] av, input logic [31:0] bv);
    longint mask, sa, sb, prod;
    mask = (longint'(1) << w) - 1;
    sa   = longint'(av) & mask;
    sb   = longint'(bv) & mask;
    if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
    if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
    prod = sa * sb;
    return 64'(prod & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int ref_lat(input int w, input logic sm, input logic [31:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    longint mag;
    int     hi;
    mag = longint'(bv) & ((longint'(1) << w) - 1);
    if (sm && mag[w-1]) mag = (longint'(1) << w) - mag;
    hi = 0;
    for (int i = 0; i < w; i++) if (mag[i]) hi = i;
    return hi + 1;
`else
    if (sm && bv[0]) return w;
    return w;
`endif
  endfunction

  function automatic logic done_of(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic [63:0] p_of(input int w);
    return (w == 8) ? 64'(p8) : 64'(p16);
  endfunction

  task automatic scramble();
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
  endtask

  task automatic run_op(input int w, input logic sm, input logic [31:0] av,
                        input logic [31:0] bv, input string tag);
    logic [63:0] exp_p;
    int          exp_lat, lat;
    bit          seen, busy_ok;
    exp_p   = ref_prod(w, sm, av, bv);
    exp_lat = ref_lat(w, sm, bv);
    @(negedge clk);
    if (w == 8) begin
      start8 = 1'b1; sm8 = sm; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start16 = 1'b1; sm16 = sm; a16 = av[15:0]; b16 = bv[15:0];
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    scramble();
    seen = 0; lat = 0; busy_ok = 1;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(posedge clk); #1;
      if (!busy_of(w)) busy_ok = 0;
      if (done_of(w)) begin seen = 1; lat = n; end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    check({tag, "_busy_held"}, 64'(busy_ok), 64'(1));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_p"}, p_of(w), exp_p);
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 64'(busy_of(w)), 64'(0));
    check({tag, "_done_after"}, 64'(done_of(w)), 64'(0));
    if (w == 8) exp_dn8++; else exp_dn16++;
  endtask

  initial begin
    int pulses, first, exp_lat;
    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    #12;
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_done8", 64'(done8), 64'(0));
    check("rst_p8", 64'(p8), 64'(0));
    check("rst_busy16", 64'(busy16), 64'(0));
    check("rst_done16", 64'(done16), 64'(0));
    check("rst_p16", 64'(p16), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // directed cases
    run_op(8, 1'b0, 32'hFF, 32'hFF, "u_ff_ff");
    run_op(8, 1'b1, 32'h80, 32'h80, "s_min_min");
    run_op(8, 1'b1, 32'h00, 32'hFB, "s_zero_neg");
    run_op(8, 1'b0, 32'h35, 32'h01, "u_b_one");
    run_op(8, 1'b0, 32'h35, 32'h80, "u_b_msb");
    run_op(8, 1'b0, 32'h77, 32'h00, "u_b_zero");
    run_op(16, 1'b1, 32'h8000, 32'h8000, "s16_min_min");
    run_op(16, 1'b0, 32'hFFFF, 32'hFFFF, "u16_max");
    run_op(8, 1'b1, 32'hFD, 32'h07, "s_m3_7");

    // start pulses while busy are ignored
    exp_lat = ref_lat(8, 1'b0, 32'h34);
    @(negedge clk); start8 = 1'b1; sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1; start8 = 1'b0;
    pulses = 0; first = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (n == 3) begin start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      if (done8) begin
        pulses++;
        if (first == 0) first = n;
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'h81; b8 = 8'h7F;
      end
    end
    start8 = 1'b0;
    check("ign_pulses", 64'(pulses), 64'(1));
    check("ign_latency", 64'(first), 64'(exp_lat));
    check("ign_p", 64'(p8), 64'h3A8);
    check("ign_busy_end", 64'(busy8), 64'(0));
    exp_dn8++;

    // asynchronous reset in the middle of RUN
    @(negedge clk); start8 = 1'b1; sm8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy8), 64'(0));
    check("abort_done", 64'(done8), 64'(0));
    check("abort_p", 64'(p8), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    run_op(8, 1'b0, 32'h5A, 32'hC3, "after_abort");

    // randomised operations, both modes, both widths
    for (int i = 0; i < 1000; i++)
      run_op(8, 1'($urandom), $urandom, $urandom, "rnd8");
    for (int i = 0; i < 1000; i++)
      run_op(16, 1'($urandom), $urandom, $urandom, "rnd16");

    check("done_count8", 64'(dn8), 64'(exp_dn8));
    check("done_count16", 64'(dn16), 64'(exp_dn16));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
